tt_um_mux_scan: RTL
===================

Name: tt_um_mux_scan

Overview:
Parametrised N-channel registered multiplexer for the TT tile, the successor to the 2:1 combinational mux. Packs NCH channels of W = 8/NCH bits onto ui_in and selects one by manual index, continuous round-robin scan with programmable dwell, or single sweep. It also supports freeze. Output data, the current channel index and a change strobe appear on uo_out; sweep-done is driven on uio_out[7].

Parameters:
NCH, 4, channel count; legal values 2, 4, 8. W = 8/NCH (4, 2, 1). SEL_W = clog2(NCH).
DWELL_SHIFT, 2, dwell scale; dwell cycles = (code+1) << DWELL_SHIFT. Counter width = DWELL_SHIFT+2.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  tile enable; low = all registers hold
ui_in  in  8  channel data; channel c = ui_in[c*W +: W]
uio_in  in  8  [2:0] manual sel (bits >= SEL_W ignored); [4:3] mode; [6:5] dwell code; [7] unused
uo_out  out  8  [W-1:0] registered data; [W..3] zero; [6:4] idx zero-padded; [7] chg strobe
uio_out  out  8  [7] done; [6:0] = 0
uio_oe  out  8  constant 8'b1000_0000

Behaviour:
- Mode encoding: 00 MANUAL, 01 SCAN, 10 FREEZE, 11 SWEEP. Internal states: MANUAL, SCAN, FREEZE, SWEEP, SWEEP_DONE. mode_q registers the last mode.
- Reset, async, any time: idx=0, dout=0, chg=0, done=0, cnt=0, mode_q=00. Outputs read 0 during reset. Reset mid-scan or mid-sweep aborts immediately.
- Each enabled clock, compute idx_next, then: idx<=idx_next; dout<=chan(idx_next); chg<=(idx_next!=idx). In FREEZE, dout holds instead.
- Latency: one clock from any ui_in or uio_in change to uo_out. chg is high exactly in the cycle dout first shows the new channel.
- Mode change (mode != mode_q): cnt<=0; done<=0. Entering SWEEP forces idx_next=0. Other entries keep the current idx.
- MANUAL: idx_next = sel[SEL_W-1:0].
- SCAN: idx_next = idx, and cnt increments. When cnt >= dwell-1: idx_next = (idx==NCH-1) ? 0 : idx+1, and cnt<=0.
  - The ">=" compare makes a mid-count dwell-code decrease advance on the next cycle and never overrun.
- FREEZE: idx, dout and cnt hold; chg=0. ui_in changes are ignored.
- SWEEP: same stepping as SCAN. When the dwell expires on channel NCH-1, go to SWEEP_DONE: idx stays NCH-1, done<=1, no chg pulse.
- SWEEP_DONE: idx held; dout keeps tracking channel NCH-1; done stays 1 until the mode changes. Re-arm by leaving and re-entering mode 11.
- ena=0: every register holds, including cnt and mode_q. A mode change made while ena=0 is acted on at the first enabled cycle.
- Simultaneous events: reset dominates, then ena=0, then mode change, then dwell expiry.

Test Plan:
NCH=4, DWELL_SHIFT=2; ui_in=8'b11_10_01_00 (ch0=00, ch1=01, ch2=10, ch3=11).
1. Reset, then MANUAL sel=2 -> next cycle uo_out[1:0]=10, [6:4]=010, [7]=1 for one cycle. sel=5 -> treated as 1: uo_out[1:0]=01.
2. SCAN, code 0 (4 cycles) from idx 0 -> idx 0,1,2,3,0 each held 4 cycles; chg pulses every 4th cycle; the step after 3 wraps to 0.
3. SWEEP, code 1 (8 cycles) from idx 2 -> idx 0 next cycle with chg=1. 8 cycles on each of 0..3, then done=1 and idx=3 held. MANUAL then clears done.
4. SCAN mid-dwell then FREEZE; change ui_in to 8'hFF -> uo_out frozen, chg=0. Return to SCAN -> cnt restarts at 0 and data updates in 1 cycle.
5. ena=0 for 10 cycles during SCAN -> idx and cnt frozen; scan resumes with the same remaining dwell.
6. Assert rst_n low mid-sweep, asynchronous to clk -> uo_out=0 and done=0 immediately. After release, MANUAL state with idx 0.

Source files
------------

// File: rtl/tt_um_mux_scan.sv
// Registered N-channel multiplexer for the TT tile.
// It selects a channel by manual index, by round-robin scan with a programmable dwell, or by a single sweep, and it can also freeze.
module tt_um_mux_scan #(
  parameter int NCH         = 4,
  parameter int DWELL_SHIFT = 2
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int W     = 8 / NCH;
  localparam int SEL_W = $clog2(NCH);
  localparam int CW    = DWELL_SHIFT + 2;

  localparam logic [1:0]       MODE_MANUAL = 2'b00;
  localparam logic [1:0]       MODE_SCAN   = 2'b01;
  localparam logic [1:0]       MODE_FREEZE = 2'b10;
  localparam logic [1:0]       MODE_SWEEP  = 2'b11;
  localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(NCH - 1);
  localparam logic [SEL_W-1:0] IDX_ONE     = SEL_W'(1);
  localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
  localparam logic [CW:0]      DWELL_ONE   = (CW + 1)'(1);

  typedef enum logic [2:0] {
    ST_MANUAL,
    ST_SCAN,
    ST_FREEZE,
    ST_SWEEP,
    ST_SWEEP_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [W-1:0]     dout_q, dout_d;
  logic             chg_q, chg_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [1:0]       mode_in;
  logic [1:0]       code_in;
  logic [SEL_W-1:0] sel_in;
  logic             mode_chg;
  logic [CW:0]      dwell_m1;
  logic             expire;
  logic [W-1:0]     chans [NCH];
  logic             unused_bits;

  assign mode_in     = uio_in[4:3];
  assign code_in     = uio_in[6:5];
  assign sel_in      = uio_in[SEL_W-1:0];
  assign mode_chg    = (mode_in != mode_q);
  assign unused_bits = ^{uio_in[7], uio_in[2:0]};

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign chans[c] = ui_in[c*W +: W];
  end

  // The dwell compare is ">=" so a shorter dwell code applied mid-count expires at once instead of wrapping the counter.
  always_comb begin
    dwell_m1 = (({{(CW - 1){1'b0}}, code_in} + DWELL_ONE) << DWELL_SHIFT) - DWELL_ONE;
    expire   = ({1'b0, cnt_q} >= dwell_m1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_MANUAL;
      mode_q  <= MODE_MANUAL;
      idx_q   <= '0;
      dout_q  <= '0;
      chg_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (ena) begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      chg_q   <= chg_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_in;
    if (mode_chg) begin
      unique case (mode_in)
        MODE_MANUAL: state_d = ST_MANUAL;
        MODE_SCAN:   state_d = ST_SCAN;
        MODE_FREEZE: state_d = ST_FREEZE;
        default:     state_d = ST_SWEEP;
      endcase
    end else if (state_q == ST_SWEEP && expire && idx_q == LAST_IDX) begin
      state_d = ST_SWEEP_DONE;
    end
  end

  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    done_d = done_q;
    if (mode_chg) begin
      cnt_d  = '0;
      done_d = 1'b0;
      if (mode_in == MODE_SWEEP) idx_d = '0;
    end else begin
      unique case (state_q)
        ST_MANUAL: idx_d = sel_in;
        ST_SCAN, ST_SWEEP: begin
          if (expire) begin
            cnt_d = '0;
            if (state_q == ST_SWEEP && idx_q == LAST_IDX) done_d = 1'b1;
            else idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
    dout_d = (mode_in == MODE_FREEZE) ? dout_q : chans[idx_d];
    chg_d  = (idx_d != idx_q);
  end

  always_comb begin
    uo_out              = '0;
    uo_out[W-1:0]       = dout_q;
    uo_out[4 +: SEL_W]  = idx_q;
    uo_out[7]           = chg_q;
    uio_out             = {done_q, 7'b000_0000};
    uio_oe              = 8'b1000_0000;
  end

endmodule
